// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store front end for a word-only data memory.
// Performs byte/half lane extraction with sign/zero extension on loads and
// sub-word stores by read-modify-write. Requests use a valid/ready handshake
// and each one completes with a single-cycle resp_valid pulse.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   req_valid/ready     request handshake (ready high iff idle)
//   req_write           1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_signed          loads: sign-extend when set
//   req_addr            byte address
//   req_wdata           store data (low lane used for sub-word stores)
//   resp_valid/err      completion pulse and its error qualifier
//   resp_rdata          last successful load result
//   mem_addr/wdata      word address and write word to the data memory
//   mem_read/write      memory strobes, decoded from state
//   mem_rdata           combinational read data from the memory
module load_store_unit #(
  parameter int unsigned BITSIZE = 32,
  parameter int unsigned MEMSIZE = 64,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [1:0]                 req_size,
  input  logic                       req_signed,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [BITSIZE-1:0]         req_wdata,
  output logic                       resp_valid,
  output logic                       resp_err,
  output logic [BITSIZE-1:0]         resp_rdata,
  output logic [$clog2(MEMSIZE)-1:0] mem_addr,
  output logic [BITSIZE-1:0]         mem_wdata,
  output logic                       mem_read,
  output logic                       mem_write,
  input  logic [BITSIZE-1:0]         mem_rdata
);

  localparam int unsigned MemAw = $clog2(MEMSIZE);
  localparam logic [ADDR_W-1:0] AddrLimit = ADDR_W'(4 * MEMSIZE);

  typedef enum logic [1:0] {StIdle, StLoad, StStore, StMerge} state_e;

  state_e               state_q, state_d;
  logic [1:0]           size_q;
  logic [1:0]           lane_q;
  logic                 signed_q;
  logic                 resp_valid_q;
  logic                 resp_err_q;
  logic [BITSIZE-1:0]   rdata_q;
  logic [MemAw-1:0]     mem_addr_q;
  logic [BITSIZE-1:0]   mem_wdata_q;

  logic                 accept;
  logic                 req_err;
  logic [7:0]           load_byte;
  logic [15:0]          load_half;
  logic [BITSIZE-1:0]   load_data;
  logic [BITSIZE-1:0]   merge_data;

  assign accept     = req_valid && (state_q == StIdle);
  assign req_ready  = (state_q == StIdle);
  assign mem_read   = (state_q == StLoad) || (state_q == StMerge);
  assign mem_write  = (state_q == StStore);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  // Alignment, size legality and range check on the incoming request.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (req_addr >= AddrLimit) req_err = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept && !req_err) begin
          if (!req_write)              state_d = StLoad;
          else if (req_size == 2'b10)  state_d = StStore;
          else                         state_d = StMerge;
        end
      end
      StLoad:  state_d = StIdle;
      StMerge: state_d = StStore;
      StStore: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Little-endian lane extraction and extension for loads.
  always_comb begin
    load_byte = mem_rdata[{lane_q, 3'b000} +: 8];
    load_half = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_data = {{24{signed_q & load_byte[7]}}, load_byte};
      2'b01:   load_data = {{16{signed_q & load_half[15]}}, load_half};
      default: load_data = mem_rdata;
    endcase
  end

  // Sub-word store: mem_wdata_q still holds the raw store data at this point.
  always_comb begin
    merge_data = mem_rdata;
    if (size_q == 2'b00) merge_data[{lane_q, 3'b000} +: 8] = mem_wdata_q[7:0];
    else                 merge_data[{lane_q[1], 4'b0000} +: 16] = mem_wdata_q[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      signed_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (req_err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              size_q     <= req_size;
              lane_q     <= req_addr[1:0];
              signed_q   <= req_signed;
              mem_addr_q <= req_addr[MemAw+1:2];
              if (req_write) mem_wdata_q <= req_wdata;
            end
          end
        end
        StLoad: begin
          rdata_q      <= load_data;
          resp_valid_q <= 1'b1;
        end
        StMerge: mem_wdata_q <= merge_data;
        StStore: resp_valid_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed requests with literal expectations plus a
// per-cycle scoreboard driven by a request-level model of the unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit #(.BITSIZE(32), .MEMSIZE(64), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT.
  logic [31:0] mem [64];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  // Running strobe counts for the directed checks.
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [5:0] last_wr_addr = 6'h0;
  always @(negedge clk) begin
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_write) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= mem_addr;
    end
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Request-level model: on each accepted request it lays out the expected
  // per-cycle outputs (slot 0 = the cycle after the accept edge).
  typedef struct packed {
    logic        busy;
    logic        rd;
    logic        wr;
    logic        vld;
    logic        err;
    logic        upd;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } slot_t;

  initial begin
    logic [31:0] model_mem [64];
    slot_t       sched [4];
    slot_t       s;
    logic [31:0] cur_rdata;
    logic [31:0] a, w, v, nw, mask;
    logic [5:0]  wi;
    int unsigned k, sh;
    logic        bad;
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) sched[i] = '0;
    cur_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_resp_err", resp_err, 1'b0);
        chk32("rst_resp_rdata", resp_rdata, 32'h0);
        chk32("rst_mem_addr", {26'h0, mem_addr}, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        for (int i = 0; i < 4; i++) sched[i] = '0;
        cur_rdata = 32'h0;
      end else begin
        s = sched[0];
        if (s.upd) cur_rdata = s.rdata;
        chk1("sb_req_ready", req_ready, !s.busy);
        chk1("sb_resp_valid", resp_valid, s.vld);
        if (s.vld) chk1("sb_resp_err", resp_err, s.err);
        chk32("sb_resp_rdata", resp_rdata, cur_rdata);
        chk1("sb_mem_read", mem_read, s.rd);
        chk1("sb_mem_write", mem_write, s.wr);
        if (s.rd || s.wr) chk32("sb_mem_addr", {26'h0, mem_addr}, {26'h0, s.addr});
        if (s.wr) begin
          chk32("sb_mem_wdata", mem_wdata, s.wdata);
          model_mem[s.addr] = s.wdata;
        end
        for (int i = 0; i < 3; i++) sched[i] = sched[i+1];
        sched[3] = '0;
        if (req_valid && !s.busy) begin
          a  = req_addr;
          k  = a % 4;
          bad = (req_size == 2'b11) || (req_size == 2'b01 && (k % 2) != 0) ||
                (req_size == 2'b10 && k != 0) || (a >= 32'd256);
          if (bad) begin
            sched[0].vld = 1'b1;
            sched[0].err = 1'b1;
          end else begin
            wi = 6'(a / 4);
            w  = model_mem[wi];
            if (!req_write) begin
              if (req_size == 2'b00) begin
                v = (w >> (8 * k)) & 32'hFF;
                if (req_signed && v >= 32'd128) v = v - 32'd256;
              end else if (req_size == 2'b01) begin
                v = (w >> (16 * (k / 2))) & 32'hFFFF;
                if (req_signed && v >= 32'd32768) v = v - 32'd65536;
              end else begin
                v = w;
              end
              sched[0].busy = 1'b1; sched[0].rd = 1'b1; sched[0].addr = wi;
              sched[1].vld = 1'b1; sched[1].upd = 1'b1; sched[1].rdata = v;
            end else if (req_size == 2'b10) begin
              sched[0].busy = 1'b1; sched[0].wr = 1'b1; sched[0].addr = wi;
              sched[0].wdata = req_wdata;
              sched[1].vld = 1'b1;
            end else begin
              mask = (req_size == 2'b00) ? 32'hFF : 32'hFFFF;
              sh   = (req_size == 2'b00) ? 8 * k : 16 * (k / 2);
              nw   = (w & ~(mask << sh)) | ((req_wdata & mask) << sh);
              sched[0].busy = 1'b1; sched[0].rd = 1'b1; sched[0].addr = wi;
              sched[1].busy = 1'b1; sched[1].wr = 1'b1; sched[1].addr = wi;
              sched[1].wdata = nw;
              sched[2].vld = 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue one request and wait for its response; lat counts edges from accept.
  task automatic req(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic err, output logic [31:0] rd);
    logic rdy;
    logic got;
    int   guard;
    @(posedge clk);
    #1;
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    rdy = 1'b0;
    guard = 0;
    while (!rdy && guard < 20) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      guard++;
    end
    #1 req_valid = 1'b0;
    if (!rdy) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: req_ready never high for addr %h", a);
    end
    lat = 0; got = 1'b0; err = 1'b0; rd = 32'h0;
    while (!got && lat < 8) begin
      lat++;
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        err = resp_err;
        rd  = resp_rdata;
      end else begin
        @(posedge clk);
      end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL resp_timeout: no resp_valid for addr %h", a);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic        err;
    logic [31:0] rd;
    int          rd0, wr0;
    logic [31:0] e_addr [4];
    logic [1:0]  e_size [4];
    logic        e_wr   [4];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Word store then word load.
    wr0 = wr_cnt;
    req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, err, rd);
    chk32("sw_latency", lat, 2);
    chk1("sw_err", err, 1'b0);
    chk32("sw_write_cycles", wr_cnt - wr0, 1);
    chk32("sw_mem_addr", {26'h0, last_wr_addr}, 32'h4);
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, err, rd);
    chk32("lw_latency", lat, 2);
    chk1("lw_err", err, 1'b0);
    chk32("lw_data", rd, 32'hDEADBEEF);

    // Sub-word loads.
    req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, err, rd);
    chk32("lb_13", rd, 32'hFFFFFFDE);
    req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, err, rd);
    chk32("lbu_13", rd, 32'h000000DE);
    req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, err, rd);
    chk32("lh_12", rd, 32'hFFFFDEAD);
    req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, err, rd);
    chk32("lbu_10", rd, 32'h000000EF);
    req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, err, rd);
    chk32("lhu_10", rd, 32'h0000BEEF);

    // Byte store by read-modify-write.
    rd0 = rd_cnt; wr0 = wr_cnt;
    req(1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA55, lat, err, rd);
    chk32("sb_latency", lat, 3);
    chk32("sb_read_cycles", rd_cnt - rd0, 1);
    chk32("sb_write_cycles", wr_cnt - wr0, 1);
    chk32("sb_rdata_kept", rd, 32'h0000BEEF);
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, err, rd);
    chk32("lw_after_sb", rd, 32'hDEAD55EF);

    // Error requests.
    e_addr[0] = 32'h12;  e_size[0] = 2'b10; e_wr[0] = 1'b0;
    e_addr[1] = 32'h0F;  e_size[1] = 2'b01; e_wr[1] = 1'b1;
    e_addr[2] = 32'h100; e_size[2] = 2'b10; e_wr[2] = 1'b0;
    e_addr[3] = 32'h10;  e_size[3] = 2'b11; e_wr[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd0 = rd_cnt; wr0 = wr_cnt;
      req(e_wr[i], e_size[i], 1'b0, e_addr[i], 32'h12345678, lat, err, rd);
      chk32($sformatf("err%0d_latency", i), lat, 1);
      chk1($sformatf("err%0d_flag", i), err, 1'b1);
      chk32($sformatf("err%0d_rdata_kept", i), rd, 32'hDEAD55EF);
      chk32($sformatf("err%0d_no_read", i), rd_cnt - rd0, 0);
      chk32($sformatf("err%0d_no_write", i), wr_cnt - wr0, 0);
    end

    // Halfword store to upper half, then back-to-back loads.
    req(1'b1, 2'b10, 1'b0, 32'h14, 32'h12345678, lat, err, rd);
    req(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFFA5C3, lat, err, rd);
    chk32("sh_latency", lat, 3);
    @(posedge clk);
    #1;
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_addr = 32'h14;
    @(negedge clk);
    chk1("b2b_ready_low", req_ready, 1'b0);
    chk1("b2b_read1", mem_read, 1'b1);
    @(negedge clk);
    chk1("b2b_resp1", resp_valid, 1'b1);
    chk32("b2b_data1", resp_rdata, 32'hDEAD55EF);
    chk1("b2b_ready_in_resp", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk1("b2b_read2", mem_read, 1'b1);
    chk32("b2b_addr2", {26'h0, mem_addr}, 32'h5);
    @(negedge clk);
    chk1("b2b_resp2", resp_valid, 1'b1);
    chk32("b2b_data2", resp_rdata, 32'hA5C35678);

    // Reset during the read-modify-write of a byte store.
    wr0 = wr_cnt;
    @(posedge clk);
    #1;
    req_write = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h77;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk1("mid_rst_read", mem_read, 1'b0);
    chk1("mid_rst_write", mem_write, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    chk32("mid_rst_no_write", wr_cnt - wr0, 0);
    chk32("mid_rst_mem_word", mem[4], 32'hDEAD55EF);
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, err, rd);
    chk32("lw_after_rst", rd, 32'hDEAD55EF);
    chk1("lw_after_rst_err", err, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
